// File: rtl/multicycle_control.sv
// Multicycle RISC-V control unit. One FSM steps each instruction through
// fetch, decode and a short execute sequence on a shared ALU and a single
// memory port. Memory phases stall on mem_ready_i. Outputs decode the current
// state, with a few of them qualified by the inputs.
module multicycle_control #(
    parameter int ALU_CTRL_W  = 3,
    parameter int EXT_ALU     = 0,
    parameter int SUPPORT_BNE = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [6:0]            op_i,
    input  logic [2:0]            funct3_i,
    input  logic                  funct7_i,
    input  logic                  zero_i,
    input  logic                  mem_ready_i,
    output logic                  pc_write_o,
    output logic                  adr_src_o,
    output logic                  mem_write_o,
    output logic                  ir_write_o,
    output logic [1:0]            result_src_o,
    output logic [1:0]            alu_src_a_o,
    output logic [1:0]            alu_src_b_o,
    output logic [ALU_CTRL_W-1:0] alu_control_o,
    output logic [1:0]            imm_src_o,
    output logic                  reg_write_o,
    output logic                  illegal_o,
    output logic                  instr_done_o
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, JAL
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;

    state_e     state_q, state_d;
    logic [3:0] alu_code;
    logic [3:0] funct_alu;
    logic       funct_ok;
    logic       br_ok;

    // State register; reset lands in FETCH regardless of the memory handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Funct decode for the two EXEC states; unknown funct3 falls back to add.
    always_comb begin
        funct_alu = ALU_ADD;
        funct_ok  = 1'b1;
        case (funct3_i)
            3'b000: funct_alu = (state_q == EXECR && funct7_i) ? ALU_SUB : ALU_ADD;
            3'b010: funct_alu = ALU_SLT;
            3'b110: funct_alu = ALU_OR;
            3'b111: funct_alu = ALU_AND;
            3'b100: if (EXT_ALU != 0) funct_alu = ALU_XOR; else funct_ok = 1'b0;
            3'b001: if (EXT_ALU != 0) funct_alu = ALU_SLL; else funct_ok = 1'b0;
            3'b101: if (EXT_ALU != 0) funct_alu = funct7_i ? ALU_SRA : ALU_SRL;
                    else funct_ok = 1'b0;
            default: funct_ok = 1'b0;
        endcase
    end

    // beq is always decodable; bne only when the build enables it.
    assign br_ok = (funct3_i == 3'b000) || ((SUPPORT_BNE != 0) && (funct3_i == 3'b001));

    // Next-state and output decode; write enables are suppressed under reset.
    always_comb begin
        state_d      = state_q;
        pc_write_o   = 1'b0;
        adr_src_o    = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        result_src_o = 2'b00;
        alu_src_a_o  = 2'b00;
        alu_src_b_o  = 2'b00;
        alu_code     = ALU_ADD;
        imm_src_o    = 2'b00;
        reg_write_o  = 1'b0;
        illegal_o    = 1'b0;
        instr_done_o = 1'b0;
        case (state_q)
            FETCH: begin
                alu_src_b_o  = 2'b10;
                result_src_o = 2'b10;
                ir_write_o   = mem_ready_i;
                pc_write_o   = mem_ready_i;
                if (mem_ready_i) state_d = DECODE;
            end
            DECODE: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
                imm_src_o   = 2'b10;
                case (op_i)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_R:              state_d = EXECR;
                    OP_I:              state_d = EXECI;
                    OP_JAL:            state_d = JAL;
                    OP_BRANCH: begin
                        if (br_ok) state_d = BRANCH;
                        else begin
                            state_d   = FETCH;
                            illegal_o = 1'b1;
                        end
                    end
                    default: begin
                        state_d   = FETCH;
                        illegal_o = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                imm_src_o   = op_i[5] ? 2'b01 : 2'b00;
                state_d     = op_i[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src_o = 1'b1;
                if (mem_ready_i) state_d = MEMWB;
            end
            MEMWB: begin
                result_src_o = 2'b01;
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
                state_d      = FETCH;
            end
            MEMWRITE: begin
                adr_src_o    = 1'b1;
                mem_write_o  = 1'b1;
                instr_done_o = mem_ready_i;
                if (mem_ready_i) state_d = FETCH;
            end
            EXECR, EXECI: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = (state_q == EXECI) ? 2'b01 : 2'b00;
                alu_code    = funct_alu;
                illegal_o   = !funct_ok;
                state_d     = ALUWB;
            end
            ALUWB: begin
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
                state_d      = FETCH;
            end
            BRANCH: begin
                alu_src_a_o  = 2'b10;
                alu_code     = ALU_SUB;
                pc_write_o   = (funct3_i == 3'b001) ? !zero_i : zero_i;
                instr_done_o = 1'b1;
                state_d      = FETCH;
            end
            JAL: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
                pc_write_o  = 1'b1;
                imm_src_o   = 2'b11;
                state_d     = ALUWB;
            end
            default: state_d = FETCH;
        endcase
        if (rst_i) begin
            state_d      = FETCH;
            pc_write_o   = 1'b0;
            mem_write_o  = 1'b0;
            ir_write_o   = 1'b0;
            reg_write_o  = 1'b0;
            illegal_o    = 1'b0;
            instr_done_o = 1'b0;
        end
    end

    assign alu_control_o = ALU_CTRL_W'(alu_code);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two builds (base, and EXT_ALU+SUPPORT_BNE)
// share one stimulus stream and are checked every cycle against a
// phase-sequence model, plus hand-computed spot checks.
module tb_multicycle_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_i = 1'b1, mem_ready_i = 1'b0, zero_i = 1'b0;
    logic [6:0] op_i = '0;
    logic [2:0] funct3_i = '0;
    logic       funct7_i = 1'b0;
    logic [6:0] op_n = '0;
    logic [2:0] f3_n = '0;
    logic       f7_n = 1'b0;

    logic       pcw0, adr0, mw0, irw0, rw0, ill0, dn0;
    logic [1:0] res0, a0, b0, imm0;
    logic [2:0] alu0;
    logic       pcw1, adr1, mw1, irw1, rw1, ill1, dn1;
    logic [1:0] res1, a1, b1, imm1;
    logic [3:0] alu1;

    // Packed view: pcw adr mw irw res[2] a[2] b[2] alu[4] imm[2] rw ill done
    logic [18:0] o [2];
    assign o[0] = {pcw0, adr0, mw0, irw0, res0, a0, b0, {1'b0, alu0}, imm0, rw0, ill0, dn0};
    assign o[1] = {pcw1, adr1, mw1, irw1, res1, a1, b1, alu1, imm1, rw1, ill1, dn1};

    localparam int B_PCW = 18, B_ADR = 17, B_MW = 16, B_IRW = 15;
    localparam int B_RW = 2, B_ILL = 1, B_DN = 0;

    multicycle_control #(.ALU_CTRL_W(3), .EXT_ALU(0), .SUPPORT_BNE(0)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .op_i(op_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
        .zero_i(zero_i), .mem_ready_i(mem_ready_i), .pc_write_o(pcw0), .adr_src_o(adr0),
        .mem_write_o(mw0), .ir_write_o(irw0), .result_src_o(res0), .alu_src_a_o(a0),
        .alu_src_b_o(b0), .alu_control_o(alu0), .imm_src_o(imm0), .reg_write_o(rw0),
        .illegal_o(ill0), .instr_done_o(dn0));

    multicycle_control #(.ALU_CTRL_W(4), .EXT_ALU(1), .SUPPORT_BNE(1)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .op_i(op_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
        .zero_i(zero_i), .mem_ready_i(mem_ready_i), .pc_write_o(pcw1), .adr_src_o(adr1),
        .mem_write_o(mw1), .ir_write_o(irw1), .result_src_o(res1), .alu_src_a_o(a1),
        .alu_src_b_o(b1), .alu_control_o(alu1), .imm_src_o(imm1), .reg_write_o(rw1),
        .illegal_o(ill1), .instr_done_o(dn1));

    // ---------------- model: each instruction is a list of phases ----------------
    typedef enum logic [3:0] {PF, PD, PADR, PRD, PMWB, PWR, PEX, PAWB, PBR, PJAL} ph_t;

    logic [23:0] seq [2] = '{24'd0, 24'd0};
    int          idx [2] = '{0, 0};
    int          len [2] = '{1, 1};
    bit          started = 1'b0;
    int          n_cmp = 0, n_bad = 0;

    function automatic ph_t cur(int k);
        return ph_t'(seq[k][idx[k]*4 +: 4]);
    endfunction

    // Phases after fetch, first phase in the low nibble; {len, phases}.
    function automatic logic [27:0] plan(logic [6:0] op, logic [2:0] f3, bit bne);
        case (op)
            7'b0000011: return {4'd4, 8'd0, PMWB, PRD, PADR, PD};
            7'b0100011: return {4'd3, 12'd0, PWR, PADR, PD};
            7'b0110011, 7'b0010011: return {4'd3, 12'd0, PAWB, PEX, PD};
            7'b1100011: begin
                if (f3 == 3'd0 || (bne && f3 == 3'd1)) return {4'd2, 16'd0, PBR, PD};
                return {4'd1, 20'd0, PD};
            end
            7'b1101111: return {4'd3, 12'd0, PAWB, PJAL, PD};
            default:    return {4'd1, 20'd0, PD};
        endcase
    endfunction

    // {legal, alu code}
    function automatic logic [4:0] fdec(logic [2:0] f3, logic f7, bit is_r, bit ext);
        case (f3)
            3'd0: return {1'b1, (is_r && f7) ? 4'd1 : 4'd0};
            3'd2: return {1'b1, 4'd5};
            3'd6: return {1'b1, 4'd3};
            3'd7: return {1'b1, 4'd2};
            3'd4: return ext ? {1'b1, 4'd4} : 5'd0;
            3'd1: return ext ? {1'b1, 4'd6} : 5'd0;
            3'd5: return ext ? {1'b1, f7 ? 4'd8 : 4'd7} : 5'd0;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [18:0] model_out(int k);
        logic pcw, adr, mw, irw, rw, ill, dn;
        logic [1:0] res, a, b, imm;
        logic [3:0] alu;
        logic [4:0] fd;
        bit is_r;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0; dn = 0;
        res = 0; a = 0; b = 0; imm = 0; alu = 0;
        is_r = (op_i == 7'b0110011);
        case (cur(k))
            PF:   begin b = 2; res = 2; irw = mem_ready_i; pcw = mem_ready_i; end
            PD:   begin a = 1; b = 1; imm = 2; ill = (len[k] == 1); end
            PADR: begin a = 2; b = 1; imm = op_i[5] ? 2'd1 : 2'd0; end
            PRD:  adr = 1;
            PMWB: begin res = 1; rw = 1; dn = 1; end
            PWR:  begin adr = 1; mw = 1; dn = mem_ready_i; end
            PEX:  begin
                fd = fdec(funct3_i, funct7_i, is_r, k == 1);
                a = 2; b = is_r ? 2'd0 : 2'd1; alu = fd[3:0]; ill = !fd[4];
            end
            PAWB: begin rw = 1; dn = 1; end
            PBR:  begin a = 2; alu = 1; dn = 1; pcw = (funct3_i == 3'd1) ? !zero_i : zero_i; end
            PJAL: begin a = 1; b = 2; pcw = 1; imm = 3; end
            default: ;
        endcase
        if (rst_i) begin pcw = 0; mw = 0; irw = 0; rw = 0; ill = 0; dn = 0; end
        return {pcw, adr, mw, irw, res, a, b, alu, imm, rw, ill, dn};
    endfunction

    // Model advances on each edge: memory phases wait for ready, then the list moves on.
    always @(posedge clk) begin
        if (rst_i) begin
            started <= 1'b1;
            for (int k = 0; k < 2; k++) begin
                seq[k] <= {20'd0, PF}; idx[k] <= 0; len[k] <= 1;
            end
        end else if (started) begin
            for (int k = 0; k < 2; k++) begin
                if (cur(k) == PF) begin
                    if (mem_ready_i) begin
                        seq[k] <= 24'(plan(op_i, funct3_i, k == 1));
                        len[k] <= int'(plan(op_i, funct3_i, k == 1) >> 24);
                        idx[k] <= 0;
                    end
                end else if ((cur(k) == PRD || cur(k) == PWR) && !mem_ready_i) begin
                end else if (idx[k] + 1 == len[k]) begin
                    seq[k] <= {20'd0, PF}; idx[k] <= 0; len[k] <= 1;
                end else begin
                    idx[k] <= idx[k] + 1;
                end
            end
        end
    end

    // Every-cycle comparison, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (o[k] !== model_out(k)) begin
                    n_bad++;
                    $display("FAIL cycle_check dut%0d t=%0t phase=%0d: got %b want %b",
                             k, $time, cur(k), o[k], model_out(k));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [18:0] s0 [16];
    logic [18:0] s1 [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic rdy, input logic z);
        @(posedge clk);
        #1;
        rst_i = r; mem_ready_i = rdy; zero_i = z;
        op_i = op_n; funct3_i = f3_n; funct7_i = f7_n;
        #1;
    endtask

    task automatic ins(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        op_n = op; f3_n = f3; f7_n = f7;
    endtask

    task automatic run(input int n, input logic [15:0] rdy, input logic z);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, rdy[i], z);
            s0[i] = o[0];
            s1[i] = o[1];
        end
    endtask

    function automatic logic [15:0] col(int d, int b, int n);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = (d == 0) ? s0[i][b] : s1[i][b];
        return v;
    endfunction

    initial begin
        ins(7'b0110011, 3'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("reset_irw_gated", 32'(o[0][B_IRW]), 0);
        chk("reset_fetch_srcb", 32'(o[1][10:9]), 2);

        // add: F D EXECR ALUWB
        run(4, 16'hF, 1'b0);
        chk("add_alu", 32'(s0[2][8:5]), 0);
        chk("add_regwrite", 32'(col(0, B_RW, 4)), 4'b1000);
        chk("add_done", 32'(col(0, B_DN, 4)), 4'b1000);
        chk("add_irwrite", 32'(col(1, B_IRW, 4)), 4'b0001);

        ins(7'b0110011, 3'd0, 1'b1);
        run(4, 16'hF, 1'b0);
        chk("sub_alu", 32'(s0[2][8:5]), 1);

        ins(7'b0010011, 3'd6, 1'b0);
        run(4, 16'hF, 1'b0);
        chk("ori_alu", 32'(s1[2][8:5]), 3);
        chk("ori_srcb", 32'(s0[2][10:9]), 1);

        // lw: memory not ready for 3 cycles in MEMREAD
        ins(7'b0000011, 3'd2, 1'b0);
        run(8, 16'h00C7, 1'b0);
        chk("lw_done", 32'(col(0, B_DN, 8)), 8'h80);
        chk("lw_regwrite", 32'(col(0, B_RW, 8)), 8'h80);
        chk("lw_adrsrc", 32'(col(0, B_ADR, 8)), 8'h78);

        // sw: two fetch wait cycles, one write wait cycle
        ins(7'b0100011, 3'd2, 1'b0);
        run(7, 16'h005C, 1'b0);
        chk("sw_irwrite", 32'(col(0, B_IRW, 7)), 7'h04);
        chk("sw_pcwrite", 32'(col(0, B_PCW, 7)), 7'h04);
        chk("sw_memwrite", 32'(col(1, B_MW, 7)), 7'h60);
        chk("sw_immsrc", 32'(s0[4][4:3]), 1);
        chk("sw_done", 32'(col(0, B_DN, 7)), 7'h40);

        ins(7'b1100011, 3'd0, 1'b0);
        run(3, 16'h7, 1'b1);
        chk("beq_taken_pcw", 32'(col(0, B_PCW, 3)), 3'b101);
        run(3, 16'h7, 1'b0);
        chk("beq_not_taken_pcw", 32'(col(1, B_PCW, 3)), 3'b001);

        // bne: illegal on the base build, inverted branch on the other
        ins(7'b1100011, 3'd1, 1'b0);
        run(3, 16'h3, 1'b1);
        chk("bne_base_illegal", 32'(col(0, B_ILL, 3)), 3'b010);
        chk("bne_base_done", 32'(col(0, B_DN, 3)), 0);
        chk("bne_ext_pcw_zero1", 32'(col(1, B_PCW, 3)), 3'b001);
        chk("bne_ext_done", 32'(col(1, B_DN, 3)), 3'b100);
        run(3, 16'h3, 1'b0);
        chk("bne_ext_pcw_zero0", 32'(col(1, B_PCW, 3)), 3'b101);

        ins(7'h7F, 3'd0, 1'b0);
        run(2, 16'h3, 1'b0);
        chk("badop_illegal0", 32'(col(0, B_ILL, 2)), 2'b10);
        chk("badop_illegal1", 32'(col(1, B_ILL, 2)), 2'b10);
        chk("badop_done", 32'(col(0, B_DN, 2)), 0);

        ins(7'b1101111, 3'd0, 1'b0);
        run(4, 16'hF, 1'b0);
        chk("jal_pcw", 32'(col(0, B_PCW, 4)), 4'b0101);
        chk("jal_immsrc", 32'(s1[2][4:3]), 3);
        chk("jal_regwrite", 32'(col(0, B_RW, 4)), 4'b1000);

        ins(7'b0110011, 3'd5, 1'b1);
        run(4, 16'hF, 1'b0);
        chk("sra_ext_alu", 32'(s1[2][8:5]), 8);
        chk("sra_ext_illegal", 32'(col(1, B_ILL, 4)), 0);
        chk("sra_base_illegal", 32'(col(0, B_ILL, 4)), 4'b0100);
        chk("sra_base_done", 32'(col(0, B_DN, 4)), 4'b1000);

        // reset while a store is waiting on memory
        ins(7'b0100011, 3'd2, 1'b0);
        run(4, 16'h3, 1'b0);
        chk("sw_wait_memwrite", 32'(s0[3][B_MW]), 1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("rst_cycle_memwrite", 32'(o[0][B_MW]), 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("after_rst_memwrite", 32'(o[0][B_MW]), 0);
        chk("after_rst_fetch_srcb", 32'(o[0][10:9]), 2);
        chk("after_rst_irwrite", 32'(o[1][B_IRW]), 0);

        ins(7'b0110011, 3'd7, 1'b0);
        run(5, 16'h1E, 1'b0);
        chk("and_alu", 32'(s0[3][8:5]), 2);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
